// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side, forwarding and ALU-side signals of the ID/EX stage
interface id_ex_stage_if #(parameter int W = 32, parameter int RA_W = 5);
  logic            i_stall;
  logic            i_flush;
  logic            i_valid;
  logic [RA_W-1:0] i_rs_addr;
  logic [RA_W-1:0] i_rt_addr;
  logic [RA_W-1:0] i_rd_addr;
  logic [W-1:0]    i_rs_data;
  logic [W-1:0]    i_rt_data;
  logic [15:0]     i_imm;
  logic            i_imm_sext;
  logic [4:0]      i_shamt;
  logic [5:0]      i_alu_control;
  logic            i_alu_src_imm;
  logic            i_shift_imm;
  logic            i_shift_var;
  logic            i_reg_write;
  logic            i_exmem_wr;
  logic [RA_W-1:0] i_exmem_addr;
  logic [W-1:0]    i_exmem_data;
  logic            i_memwb_wr;
  logic [RA_W-1:0] i_memwb_addr;
  logic [W-1:0]    i_memwb_data;
  logic [W-1:0]    o_op1;
  logic [W-1:0]    o_op2;
  logic [5:0]      o_alu_control;
  logic [W-1:0]    o_store_data;
  logic [RA_W-1:0] o_rd_addr;
  logic            o_reg_write;
  logic            o_valid;
  modport master (
    output i_stall, i_flush, i_valid, i_rs_addr, i_rt_addr, i_rd_addr, i_rs_data, i_rt_data,
           i_imm, i_imm_sext, i_shamt, i_alu_control, i_alu_src_imm, i_shift_imm, i_shift_var,
           i_reg_write, i_exmem_wr, i_exmem_addr, i_exmem_data, i_memwb_wr, i_memwb_addr, i_memwb_data,
    input  o_op1, o_op2, o_alu_control, o_store_data, o_rd_addr, o_reg_write, o_valid
  );
  modport slave (
    input  i_stall, i_flush, i_valid, i_rs_addr, i_rt_addr, i_rd_addr, i_rs_data, i_rt_data,
           i_imm, i_imm_sext, i_shamt, i_alu_control, i_alu_src_imm, i_shift_imm, i_shift_var,
           i_reg_write, i_exmem_wr, i_exmem_addr, i_exmem_data, i_memwb_wr, i_memwb_addr, i_memwb_data,
    output o_op1, o_op2, o_alu_control, o_store_data, o_rd_addr, o_reg_write, o_valid
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX operand selection and optional forwarding.
// Define ID_EX_FWD_EN to enable EX/MEM and MEM/WB result forwarding.
module id_ex_stage #(parameter int W = 32, parameter int RA_W = 5) (
  input logic          i_clk,
  input logic          i_rst,
  id_ex_stage_if.slave bus
);
  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [RA_W-1:0] rs_addr;
    logic [RA_W-1:0] rt_addr;
    logic [RA_W-1:0] rd_addr;
    logic [W-1:0]    rs_data;
    logic [W-1:0]    rt_data;
    logic [15:0]     imm;
    logic            imm_sext;
    logic [4:0]      shamt;
    logic [5:0]      alu_control;
    logic            alu_src_imm;
    logic            shift_imm;
    logic            shift_var;
  } stage_t;
  stage_t r, d;
  logic [W-1:0] fa, fb;
  assign d = '{valid: bus.i_valid, reg_write: bus.i_reg_write & bus.i_valid,
               rs_addr: bus.i_rs_addr, rt_addr: bus.i_rt_addr, rd_addr: bus.i_rd_addr,
               rs_data: bus.i_rs_data, rt_data: bus.i_rt_data, imm: bus.i_imm,
               imm_sext: bus.i_imm_sext, shamt: bus.i_shamt, alu_control: bus.i_alu_control,
               alu_src_imm: bus.i_alu_src_imm, shift_imm: bus.i_shift_imm, shift_var: bus.i_shift_var};
  always_ff @(posedge i_clk)
    if (i_rst || bus.i_flush) r <= '0;
    else if (!bus.i_stall) r <= d;
`ifdef ID_EX_FWD_EN
  // EX/MEM is the younger result, so it takes precedence over MEM/WB
  always_comb begin
    fa = (bus.i_exmem_wr && bus.i_exmem_addr == r.rs_addr && r.rs_addr != '0) ? bus.i_exmem_data :
         (bus.i_memwb_wr && bus.i_memwb_addr == r.rs_addr && r.rs_addr != '0) ? bus.i_memwb_data : r.rs_data;
    fb = (bus.i_exmem_wr && bus.i_exmem_addr == r.rt_addr && r.rt_addr != '0) ? bus.i_exmem_data :
         (bus.i_memwb_wr && bus.i_memwb_addr == r.rt_addr && r.rt_addr != '0) ? bus.i_memwb_data : r.rt_data;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.i_exmem_wr, bus.i_exmem_addr, bus.i_exmem_data,
                        bus.i_memwb_wr, bus.i_memwb_addr, bus.i_memwb_data};
  assign fa = r.rs_data;
  assign fb = r.rt_data;
`endif
  assign bus.o_op1 = r.shift_imm ? {{(W-5){1'b0}}, r.shamt} :
                     r.shift_var ? {{(W-5){1'b0}}, fa[4:0]} : fa;
  assign bus.o_op2 = r.alu_src_imm ? {{(W-16){r.imm_sext & r.imm[15]}}, r.imm} : fb;
  assign bus.o_store_data  = fb;
  assign bus.o_alu_control = r.alu_control;
  assign bus.o_rd_addr     = r.rd_addr;
  assign bus.o_reg_write   = r.reg_write;
  assign bus.o_valid       = r.valid;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage (honours ID_EX_FWD_EN)
module tb_id_ex_stage;
  logic clk = 0, rst = 1;
  int checks = 0, fails = 0;
  id_ex_stage_if bus ();
  id_ex_stage dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic set_dec(input logic [4:0] rs_a, rt_a, rd_a, input logic [31:0] rs_d, rt_d,
                         input logic [15:0] imm, input logic sext, input logic [4:0] shamt,
                         input logic [5:0] ctrl, input logic src_imm, sh_imm, sh_var, rw, vld);
    bus.i_rs_addr = rs_a; bus.i_rt_addr = rt_a; bus.i_rd_addr = rd_a;
    bus.i_rs_data = rs_d; bus.i_rt_data = rt_d; bus.i_imm = imm; bus.i_imm_sext = sext;
    bus.i_shamt = shamt; bus.i_alu_control = ctrl; bus.i_alu_src_imm = src_imm;
    bus.i_shift_imm = sh_imm; bus.i_shift_var = sh_var; bus.i_reg_write = rw; bus.i_valid = vld;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; bus.i_stall = 1; bus.i_flush = 0;
    bus.i_exmem_wr = 0; bus.i_exmem_addr = 0; bus.i_exmem_data = 0;
    bus.i_memwb_wr = 0; bus.i_memwb_addr = 0; bus.i_memwb_data = 0;
    set_dec(5'd1, 5'd2, 5'd3, 32'hDEAD, 32'hBEEF, 16'h1234, 1, 5'd7, 6'h3F, 0, 0, 0, 1, 1);
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", bus.o_valid); end
    checks++; if (bus.o_reg_write !== 1'b0) begin fails++; $display("FAIL reset_rw got %b exp 0", bus.o_reg_write); end
    checks++; if (bus.o_alu_control !== 6'h00) begin fails++; $display("FAIL reset_ctrl got %h exp 00", bus.o_alu_control); end
    checks++; if (bus.o_op1 !== 32'h0) begin fails++; $display("FAIL reset_op1 got %h exp 0", bus.o_op1); end
    checks++; if (bus.o_op2 !== 32'h0) begin fails++; $display("FAIL reset_op2 got %h exp 0", bus.o_op2); end
    checks++; if (bus.o_store_data !== 32'h0) begin fails++; $display("FAIL reset_store got %h exp 0", bus.o_store_data); end
    rst = 0; bus.i_stall = 0;
  endtask

  task automatic test_add();
    set_dec(5'd5, 5'd6, 5'd3, 32'h10, 32'h20, 16'h0, 0, 5'd0, 6'b100000, 0, 0, 0, 1, 1);
    tick();
    checks++; if (bus.o_op1 !== 32'h10) begin fails++; $display("FAIL add_op1 got %h exp 10", bus.o_op1); end
    checks++; if (bus.o_op2 !== 32'h20) begin fails++; $display("FAIL add_op2 got %h exp 20", bus.o_op2); end
    checks++; if (bus.o_alu_control !== 6'b100000) begin fails++; $display("FAIL add_ctrl got %h exp 20", bus.o_alu_control); end
    checks++; if (bus.o_store_data !== 32'h20) begin fails++; $display("FAIL add_store got %h exp 20", bus.o_store_data); end
    checks++; if (bus.o_rd_addr !== 5'd3) begin fails++; $display("FAIL add_rd got %0d exp 3", bus.o_rd_addr); end
    checks++; if (bus.o_reg_write !== 1'b1) begin fails++; $display("FAIL add_rw got %b exp 1", bus.o_reg_write); end
    checks++; if (bus.o_valid !== 1'b1) begin fails++; $display("FAIL add_valid got %b exp 1", bus.o_valid); end
  endtask

  task automatic test_imm();
    set_dec(5'd5, 5'd6, 5'd6, 32'h10, 32'h20, 16'hFFFF, 1, 5'd0, 6'b001000, 1, 0, 0, 1, 1);
    tick();
    checks++; if (bus.o_op2 !== 32'hFFFFFFFF) begin fails++; $display("FAIL imm_sext got %h exp ffffffff", bus.o_op2); end
    checks++; if (bus.o_store_data !== 32'h20) begin fails++; $display("FAIL imm_store got %h exp 20", bus.o_store_data); end
    bus.i_imm_sext = 0;
    tick();
    checks++; if (bus.o_op2 !== 32'h0000FFFF) begin fails++; $display("FAIL imm_zext got %h exp 0000ffff", bus.o_op2); end
    set_dec(5'd5, 5'd6, 5'd6, 32'h10, 32'h20, 16'h7FFF, 1, 5'd0, 6'b001000, 1, 0, 0, 1, 1);
    tick();
    checks++; if (bus.o_op2 !== 32'h00007FFF) begin fails++; $display("FAIL imm_sext_pos got %h exp 00007fff", bus.o_op2); end
  endtask

  task automatic test_shift();
    set_dec(5'd5, 5'd6, 5'd7, 32'h123, 32'h20, 16'h0, 0, 5'd4, 6'b000000, 0, 1, 0, 1, 1);
    tick();
    checks++; if (bus.o_op1 !== 32'h4) begin fails++; $display("FAIL sll_op1 got %h exp 4", bus.o_op1); end
    bus.i_shift_imm = 0; bus.i_shift_var = 1; bus.i_alu_control = 6'b000111;
    tick();
    checks++; if (bus.o_op1 !== 32'h3) begin fails++; $display("FAIL srav_op1 got %h exp 3", bus.o_op1); end
    checks++; if (bus.o_op2 !== 32'h20) begin fails++; $display("FAIL srav_op2 got %h exp 20", bus.o_op2); end
    bus.i_shift_imm = 1;
    tick();
    checks++; if (bus.o_op1 !== 32'h4) begin fails++; $display("FAIL both_shift_op1 got %h exp 4", bus.o_op1); end
  endtask

  task automatic test_invalid();
    set_dec(5'd5, 5'd6, 5'd9, 32'h55, 32'h66, 16'h0, 0, 5'd0, 6'b100000, 0, 0, 0, 1, 0);
    tick();
    checks++; if (bus.o_reg_write !== 1'b0) begin fails++; $display("FAIL inv_rw got %b exp 0", bus.o_reg_write); end
    checks++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL inv_valid got %b exp 0", bus.o_valid); end
    checks++; if (bus.o_op1 !== 32'h55) begin fails++; $display("FAIL inv_op1 got %h exp 55", bus.o_op1); end
  endtask

  task automatic test_forward();
    logic [31:0] e_aa, e_bb, e_rt;
`ifdef ID_EX_FWD_EN
    e_aa = 32'hAA; e_bb = 32'hBB; e_rt = 32'hAA;
`else
    e_aa = 32'h11; e_bb = 32'h11; e_rt = 32'h22;
`endif
    set_dec(5'd7, 5'd7, 5'd8, 32'h11, 32'h22, 16'h0, 0, 5'd0, 6'b100000, 0, 0, 0, 1, 1);
    tick();
    bus.i_exmem_wr = 1; bus.i_exmem_addr = 5'd7; bus.i_exmem_data = 32'hAA;
    bus.i_memwb_wr = 1; bus.i_memwb_addr = 5'd7; bus.i_memwb_data = 32'hBB;
    #1;
    checks++; if (bus.o_op1 !== e_aa) begin fails++; $display("FAIL fwd_exmem_op1 got %h exp %h", bus.o_op1, e_aa); end
    checks++; if (bus.o_store_data !== e_rt) begin fails++; $display("FAIL fwd_exmem_store got %h exp %h", bus.o_store_data, e_rt); end
    bus.i_exmem_wr = 0;
    #1;
    checks++; if (bus.o_op1 !== e_bb) begin fails++; $display("FAIL fwd_memwb_op1 got %h exp %h", bus.o_op1, e_bb); end
    bus.i_exmem_wr = 1; bus.i_exmem_addr = 5'd0; bus.i_memwb_addr = 5'd0;
    set_dec(5'd0, 5'd0, 5'd8, 32'h33, 32'h44, 16'h0, 0, 5'd0, 6'b100000, 0, 0, 0, 1, 1);
    tick();
    checks++; if (bus.o_op1 !== 32'h33) begin fails++; $display("FAIL fwd_r0_op1 got %h exp 33", bus.o_op1); end
    checks++; if (bus.o_op2 !== 32'h44) begin fails++; $display("FAIL fwd_r0_op2 got %h exp 44", bus.o_op2); end
    bus.i_exmem_wr = 0; bus.i_memwb_wr = 0;
  endtask

  task automatic test_stall_flush();
    set_dec(5'd1, 5'd2, 5'd10, 32'hA1, 32'hA2, 16'h0, 0, 5'd0, 6'b100001, 0, 0, 0, 1, 1);
    tick();
    bus.i_stall = 1;
    set_dec(5'd3, 5'd4, 5'd11, 32'hB1, 32'hB2, 16'h0, 0, 5'd0, 6'b100010, 0, 0, 0, 0, 1);
    tick(); tick();
    checks++; if (bus.o_op1 !== 32'hA1) begin fails++; $display("FAIL stall_op1 got %h exp a1", bus.o_op1); end
    checks++; if (bus.o_op2 !== 32'hA2) begin fails++; $display("FAIL stall_op2 got %h exp a2", bus.o_op2); end
    checks++; if (bus.o_alu_control !== 6'b100001) begin fails++; $display("FAIL stall_ctrl got %h exp 21", bus.o_alu_control); end
    checks++; if (bus.o_rd_addr !== 5'd10) begin fails++; $display("FAIL stall_rd got %0d exp 10", bus.o_rd_addr); end
    checks++; if (bus.o_reg_write !== 1'b1) begin fails++; $display("FAIL stall_rw got %b exp 1", bus.o_reg_write); end
    bus.i_flush = 1;
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %b exp 0", bus.o_valid); end
    checks++; if (bus.o_reg_write !== 1'b0) begin fails++; $display("FAIL flush_rw got %b exp 0", bus.o_reg_write); end
    checks++; if (bus.o_op1 !== 32'h0) begin fails++; $display("FAIL flush_op1 got %h exp 0", bus.o_op1); end
    checks++; if (bus.o_alu_control !== 6'h0) begin fails++; $display("FAIL flush_ctrl got %h exp 0", bus.o_alu_control); end
    bus.i_flush = 0; bus.i_stall = 0;
    tick();
    checks++; if (bus.o_op1 !== 32'hB1) begin fails++; $display("FAIL resume_op1 got %h exp b1", bus.o_op1); end
    checks++; if (bus.o_reg_write !== 1'b0) begin fails++; $display("FAIL resume_rw got %b exp 0", bus.o_reg_write); end
    rst = 1; bus.i_stall = 1;
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL rst_over_stall got %b exp 0", bus.o_valid); end
    rst = 0; bus.i_stall = 0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_shift();
    test_invalid();
    test_forward();
    test_stall_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
